// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// FSM state encoding and the byte-lane helpers used by the aligner.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Byte-lane write enables for a store of the given size at byte offset off.
    function automatic logic [3:0] store_mask(input logic [2:0] funct3,
                                              input logic [1:0] off);
        case (funct3)
            F3_B:    store_mask = 4'b0001 << off;
            F3_H:    store_mask = 4'b0011 << {off[1], 1'b0};
            F3_W:    store_mask = 4'b1111;
            default: store_mask = 4'b0000;
        endcase
    endfunction

    // Replicate the right-aligned store operand into every lane it may land in.
    function automatic logic [31:0] store_data(input logic [2:0]  funct3,
                                               input logic [31:0] wdata);
        case (funct3)
            F3_B:    store_data = {4{wdata[7:0]}};
            F3_H:    store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

    // Pick the addressed byte/half out of a memory word and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    load_extend = {{24{b[7]}}, b};
            F3_H:    load_extend = {{16{h[15]}}, h};
            F3_W:    load_extend = word;
            F3_BU:   load_extend = {24'h000000, b};
            F3_HU:   load_extend = {16'h0000, h};
            default: load_extend = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_ram.sv
// Word-organised storage with per-byte write enables and a registered read.
// Contents are deliberately not reset.
module bytemask_ram #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    input  logic             re_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-masked write and synchronous read on the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// RV32I data-memory unit: accepts one load/store per transaction, waits
// LATENCY cycles, performs the byte-masked access and returns a one-cycle
// response with extended load data or an alignment/funct3 error.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_load_q, rsp_load_d;
    logic              accept, access, acc_err;
    logic [3:0]        ram_be;
    logic              ram_re;
    logic [31:0]       ram_rdata;

    assign accept = (state_q == IDLE) && req_valid;
    assign access = (state_q == BUSY) && (cnt_q == 3'd0);

    // Flag misaligned halves/words and funct3 codes illegal for the direction.
    always_comb begin
        acc_err = 1'b0;
        case (f3_q)
            F3_B:    acc_err = 1'b0;
            F3_H:    acc_err = addr_q[0];
            F3_W:    acc_err = (addr_q[1:0] != 2'b00);
            F3_BU:   acc_err = we_q;
            F3_HU:   acc_err = we_q | addr_q[0];
            default: acc_err = 1'b1;
        endcase
    end

    // State and latency counter, cleared asynchronously so a pending store is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: IDLE -> BUSY on accept, BUSY counts down, RESP lasts one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; the response is formed on the access edge.
    always_comb begin
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = access;
        rsp_err_d   = access & acc_err;
        rsp_load_d  = access & ~we_q & ~acc_err;
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else begin
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_load_q  <= rsp_load_d;
        end
    end

    // Request latch: captured only on acceptance, held through BUSY and RESP.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    assign ram_be = (access && we_q && !acc_err) ? store_mask(f3_q, addr_q[1:0]) : 4'b0000;
    assign ram_re = access && !we_q && !acc_err;

    bytemask_ram #(
        .DEPTH (2 ** (ADDR_W - 2)),
        .IDX_W (ADDR_W - 2)
    ) u_ram (
        .clk     (clk),
        .idx_i   (addr_q[ADDR_W-1:2]),
        .be_i    (ram_be),
        .wdata_i (store_data(f3_q, wdata_q)),
        .re_i    (ram_re),
        .rdata_o (ram_rdata)
    );

    // The RAM word lands in its read register on the access edge; the lane
    // select/extend is a mux off that register and the held request, gated
    // by a flop so the bus reads zero outside a good load response.
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_load_q ? load_extend(f3_q, addr_q[1:0], ram_rdata) : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: instance 0 runs LATENCY=1, instance 1 runs LATENCY=3.
module tb_dmem_lsu;

    logic        clk;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic [9:0]  req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    dmem_lsu #(.ADDR_W(10), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    dmem_lsu #(.ADDR_W(10), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t q0[$];
    rsp_t q1[$];
    vec_t vt[$];
    int   errors = 0;
    int   checks = 0;
    logic prev_v [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push_exp(input int d, input string name, input logic [31:0] r, input logic e);
        rsp_t x;
        x.name  = name;
        x.rdata = r;
        x.err   = e;
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    // Scoreboard: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d] === 1'b1) begin
                rsp_t x;
                chk($sformatf("pulse%0d", d), {31'b0, prev_v[d]}, 32'd0);
                if (qsize(d) == 0) begin
                    chk($sformatf("unexpected_rsp%0d", d), 32'd1, 32'd0);
                end else begin
                    x = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk({x.name, "_rdata"}, rsp_rdata[d], x.rdata);
                    chk({x.name, "_err"}, {31'b0, rsp_err[d]}, {31'b0, x.err});
                end
            end
            prev_v[d] = rsp_valid[d];
        end
    end

    task automatic drive(input int d, input logic v, input logic we, input logic [2:0] f3,
                         input logic [9:0] a, input logic [31:0] wd);
        req_valid[d]  = v;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
    endtask

    task automatic wait_ready(input int d);
        int n = 0;
        @(negedge clk);
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready[d] !== 1'b1) chk($sformatf("ready_timeout%0d", d), 32'd0, 32'd1);
    endtask

    task automatic wait_drain(input int d);
        int n = 0;
        while (qsize(d) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (qsize(d) != 0) begin
            chk($sformatf("rsp_timeout%0d", d), qsize(d), 32'd0);
            if (d == 0) q0.delete();
            else        q1.delete();
        end
    endtask

    task automatic txn(input int d, input vec_t v);
        wait_ready(d);
        drive(d, 1'b1, v.we, v.f3, v.addr, v.wdata);
        push_exp(d, v.name, v.rdata, v.err);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        wait_drain(d);
    endtask

    function automatic vec_t mk(input string n, input logic we, input logic [2:0] f3,
                                input logic [9:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic e);
        vec_t v;
        v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = e;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]    = 1'b1;
            prev_v[d] = 1'b0;
            drive(d, 1'b0, 1'b0, 3'b000, 10'h000, 32'h0);
        end

        vt.push_back(mk("sw_dead",   1, 3'b010, 10'h004, 32'hDEADBEEF, 32'h00000000, 0));
        vt.push_back(mk("lw_dead",   0, 3'b010, 10'h004, 32'h0,        32'hDEADBEEF, 0));
        vt.push_back(mk("sb_80",     1, 3'b000, 10'h005, 32'h00000080, 32'h00000000, 0));
        vt.push_back(mk("lb_80",     0, 3'b000, 10'h005, 32'h0,        32'hFFFFFF80, 0));
        vt.push_back(mk("lbu_80",    0, 3'b100, 10'h005, 32'h0,        32'h00000080, 0));
        vt.push_back(mk("lw_after_sb", 0, 3'b010, 10'h004, 32'h0,      32'hDEAD80EF, 0));
        vt.push_back(mk("sh_1234",   1, 3'b001, 10'h006, 32'h00001234, 32'h00000000, 0));
        vt.push_back(mk("lw_after_sh", 0, 3'b010, 10'h004, 32'h0,      32'h123480EF, 0));
        vt.push_back(mk("lh_hi",     0, 3'b001, 10'h006, 32'h0,        32'h00001234, 0));
        vt.push_back(mk("lhu_lo",    0, 3'b101, 10'h004, 32'h0,        32'h000080EF, 0));
        vt.push_back(mk("lw_misal",  0, 3'b010, 10'h002, 32'h0,        32'h00000000, 1));
        vt.push_back(mk("sh_misal",  1, 3'b001, 10'h005, 32'h0000FFFF, 32'h00000000, 1));
        vt.push_back(mk("lw_intact", 0, 3'b010, 10'h004, 32'h0,        32'h123480EF, 0));
        vt.push_back(mk("ld_f3_011", 0, 3'b011, 10'h004, 32'h0,        32'h00000000, 1));
        vt.push_back(mk("st_f3_100", 1, 3'b100, 10'h004, 32'h00000000, 32'h00000000, 1));
        vt.push_back(mk("st_f3_011", 1, 3'b011, 10'h004, 32'hFFFFFFFF, 32'h00000000, 1));
        vt.push_back(mk("lw_intact2", 0, 3'b010, 10'h004, 32'h0,       32'h123480EF, 0));
        vt.push_back(mk("sb_junk",   1, 3'b000, 10'h004, 32'hAABBCC7F, 32'h00000000, 0));
        vt.push_back(mk("lw_sb_junk", 0, 3'b010, 10'h004, 32'h0,       32'h1234807F, 0));
        vt.push_back(mk("lh_neg",    0, 3'b001, 10'h004, 32'h0,        32'hFFFF807F, 0));
        vt.push_back(mk("lb_lane3",  0, 3'b000, 10'h007, 32'h0,        32'h00000012, 0));
        vt.push_back(mk("lbu_lane2", 0, 3'b100, 10'h006, 32'h0,        32'h00000034, 0));
        vt.push_back(mk("lh_odd",    0, 3'b001, 10'h005, 32'h0,        32'h00000000, 1));
        vt.push_back(mk("sw_top",    1, 3'b010, 10'h3FC, 32'hCAFEF00D, 32'h00000000, 0));
        vt.push_back(mk("lw_top",    0, 3'b010, 10'h3FC, 32'h0,        32'hCAFEF00D, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready%0d", d), {31'b0, req_ready[d]}, 32'd1);
            chk($sformatf("rst_valid%0d", d), {31'b0, rsp_valid[d]}, 32'd0);
            chk($sformatf("rst_rdata%0d", d), rsp_rdata[d], 32'd0);
            chk($sformatf("rst_err%0d", d),   {31'b0, rsp_err[d]}, 32'd0);
        end

        // LATENCY=1 vector table.
        foreach (vt[i]) txn(0, vt[i]);

        // LATENCY=1 cycle-accurate load timing.
        wait_ready(0);
        drive(0, 1'b1, 1'b0, 3'b010, 10'h004, 32'h0);
        push_exp(0, "l1_timed_lw", 32'h1234807F, 1'b0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("l1_e0_ready", {31'b0, req_ready[0]}, 32'd0);
        chk("l1_e0_valid", {31'b0, rsp_valid[0]}, 32'd0);
        @(negedge clk);
        chk("l1_e1_valid", {31'b0, rsp_valid[0]}, 32'd1);
        chk("l1_e1_ready", {31'b0, req_ready[0]}, 32'd0);
        @(negedge clk);
        chk("l1_e2_valid", {31'b0, rsp_valid[0]}, 32'd0);
        chk("l1_e2_ready", {31'b0, req_ready[0]}, 32'd1);
        chk("l1_e2_rdata", rsp_rdata[0], 32'd0);
        wait_drain(0);

        // LATENCY=3: preload, then back-to-back with req_valid held high.
        txn(1, mk("l3_pre", 1, 3'b010, 10'h008, 32'h11111111, 32'h0, 0));
        wait_ready(1);
        drive(1, 1'b1, 1'b1, 3'b010, 10'h00C, 32'hA5A5A5A5);
        push_exp(1, "b2b_sw", 32'h0, 1'b0);
        @(posedge clk);
        #1 drive(1, 1'b1, 1'b0, 3'b010, 10'h00C, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_busy%0d", k), {31'b0, req_ready[1]}, 32'd0);
            chk($sformatf("b2b_valid%0d", k), {31'b0, rsp_valid[1]}, (k == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("b2b_e4_ready", {31'b0, req_ready[1]}, 32'd1);
        chk("b2b_e4_valid", {31'b0, rsp_valid[1]}, 32'd0);
        push_exp(1, "b2b_lw", 32'hA5A5A5A5, 1'b0);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        chk("b2b_e5_taken", {31'b0, req_ready[1]}, 32'd0);
        wait_drain(1);

        // LATENCY=3: reset before the access edge drops the store.
        wait_ready(1);
        drive(1, 1'b1, 1'b1, 3'b010, 10'h008, 32'hFFFFFFFF);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(posedge clk);
        #2 rst[1] = 1'b1;
        #1;
        chk("abort_ready", {31'b0, req_ready[1]}, 32'd1);
        chk("abort_valid", {31'b0, rsp_valid[1]}, 32'd0);
        chk("abort_rdata", rsp_rdata[1], 32'd0);
        chk("abort_err",   {31'b0, rsp_err[1]}, 32'd0);
        @(negedge clk);
        #1 rst[1] = 1'b0;
        txn(1, mk("abort_lw", 0, 3'b010, 10'h008, 32'h0, 32'h11111111, 0));

        // LATENCY=3: reset after the access edge keeps the store.
        wait_ready(1);
        drive(1, 1'b1, 1'b1, 3'b010, 10'h010, 32'h22222222);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst[1] = 1'b1;
        #1;
        chk("late_rst_valid", {31'b0, rsp_valid[1]}, 32'd0);
        chk("late_rst_ready", {31'b0, req_ready[1]}, 32'd1);
        @(negedge clk);
        #1 rst[1] = 1'b0;
        txn(1, mk("commit_lw", 0, 3'b010, 10'h010, 32'h0, 32'h22222222, 0));

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
